// File: rtl/data_mem_port_pkg.sv
// data_mem_port_pkg
// Shared definitions for the data-side memory port: dfunc encodings (equal to
// opcode[2:0]), FSM state encoding, the big-endian lane helper and the
// alignment/legality check used at acceptance time.
package data_mem_port_pkg;

  localparam logic [2:0] DF_LB  = 3'b000;
  localparam logic [2:0] DF_LH  = 3'b001;
  localparam logic [2:0] DF_LWL = 3'b010;
  localparam logic [2:0] DF_LW  = 3'b011;
  localparam logic [2:0] DF_LBU = 3'b100;
  localparam logic [2:0] DF_LHU = 3'b101;
  localparam logic [2:0] DF_LWR = 3'b110;
  localparam logic [2:0] DF_ILL = 3'b111;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RD     = 3'd1;
  localparam logic [2:0] ST_RMW_RD = 3'd2;
  localparam logic [2:0] ST_WR     = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // Bit position of the least significant bit of byte lane 'lane' in a
  // big-endian word: lane 0 is [31:24] -> 24, lane 3 is [7:0] -> 0.
  function automatic logic [4:0] big_endian(input logic [1:0] lane);
    return {~lane, 3'b000};
  endfunction

  function automatic logic access_err(input logic [2:0] f, input logic [1:0] b);
    logic e;
    e = 1'b0;
    if (f == DF_ILL) e = 1'b1;
    if ((f == DF_LH || f == DF_LHU) && b[0]) e = 1'b1;
    if (f == DF_LW && b != 2'b00) e = 1'b1;
    return e;
  endfunction

endpackage

// File: rtl/data_mem_port_align.sv
// mem_align
// Purely combinational lane logic for the data port.
//   dfunc, b      : access type and byte offset (latched copies)
//   word          : word read from the SRAM
//   wdata, rt_old : store data and current rt value
//   load_data     : extracted / sign-extended / merged load result
//   store_word    : word to write back for a read-modify-write store
module mem_align
  import data_mem_port_pkg::*;
(
  input  logic [2:0]  dfunc,
  input  logic [1:0]  b,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [31:0] rt_old,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  logic [4:0]  sh_b;
  logic [4:0]  sh_h;
  logic [4:0]  sh_l;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    sh_b   = big_endian(b);
    // Halfwords are aligned (b is 0 or 2), so the low lane is b|1.
    sh_h   = big_endian(b | 2'b01);
    sh_l   = {b, 3'b000};
    byte_v = word[sh_b +: 8];
    half_v = word[sh_h +: 16];

    load_data = 32'h0;
    case (dfunc)
      DF_LB:  load_data = {{24{byte_v[7]}}, byte_v};
      DF_LBU: load_data = {24'h0, byte_v};
      DF_LH:  load_data = {{16{half_v[15]}}, half_v};
      DF_LHU: load_data = {16'h0, half_v};
      DF_LW:  load_data = word;
      DF_LWL: load_data = (word << sh_l) | (rt_old & ~(ONES << sh_l));
      DF_LWR: load_data = (word >> sh_b) | (rt_old & ~(ONES >> sh_b));
      default: load_data = 32'h0;
    endcase

    store_word = wdata;
    case (dfunc)
      DF_LB, DF_LBU:
        store_word = (word & ~(32'h0000_00FF << sh_b)) | ({24'h0, wdata[7:0]} << sh_b);
      DF_LH, DF_LHU:
        store_word = (word & ~(32'h0000_FFFF << sh_h)) | ({16'h0, wdata[15:0]} << sh_h);
      DF_LWL:
        store_word = (word & ~(ONES >> sh_l)) | (wdata >> sh_l);
      DF_LWR:
        store_word = (word & ~(ONES << sh_b)) | (wdata << sh_b);
      default:
        store_word = wdata;
    endcase
  end

endmodule

// File: rtl/data_mem_port.sv
// data_mem_port
// Load/store responder between the core controller and a word-wide,
// handshaked data SRAM without byte enables. Sub-word and unaligned stores
// are done as read-modify-write; illegal/misaligned accesses finish without
// touching the SRAM.
//   clk, _reset        : core clock, async active-low reset
//   req, rw, dfunc     : command (sampled in IDLE only)
//   addr, wdata, rt_old: effective address, store data, rt for lwl/lwr merge
//   rdata, done, err   : result, one-cycle completion pulse, error flag
//   busy               : access in progress (not set in DONE)
//   mem_*              : SRAM word address, strobes, data and ack
//
// state     | meaning
// IDLE      | waiting for req
// RD        | load read, mem_rd held until ack
// RMW_RD    | read half of a read-modify-write store
// WR        | write, mem_wr held with buffered data until ack
// DONE      | done pulse, req ignored
module data_mem_port
  import data_mem_port_pkg::*;
(
  input  logic        clk,
  input  logic        _reset,
  input  logic        req,
  input  logic        rw,
  input  logic [2:0]  dfunc,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rt_old,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic        busy,
  output logic [29:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  logic [2:0]  state;
  logic [2:0]  dfunc_q;
  logic [1:0]  b_q;
  logic [31:0] wdata_q;
  logic [31:0] rt_old_q;
  logic [31:0] load_data;
  logic [31:0] store_word;

  mem_align u_align (
    .dfunc      (dfunc_q),
    .b          (b_q),
    .word       (mem_rdata),
    .wdata      (wdata_q),
    .rt_old     (rt_old_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  assign busy = (state == ST_RD) || (state == ST_RMW_RD) || (state == ST_WR);

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state     <= ST_IDLE;
      dfunc_q   <= 3'h0;
      b_q       <= 2'h0;
      wdata_q   <= 32'h0;
      rt_old_q  <= 32'h0;
      rdata     <= 32'h0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_addr  <= 30'h0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_wdata <= 32'h0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            mem_addr <= addr[31:2];
            dfunc_q  <= dfunc;
            b_q      <= addr[1:0];
            wdata_q  <= wdata;
            rt_old_q <= rt_old;
            rdata    <= 32'h0;
            err      <= 1'b0;
            if (access_err(dfunc, addr[1:0])) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= ST_DONE;
            end else if (!rw) begin
              mem_rd <= 1'b1;
              state  <= ST_RD;
            end else if (dfunc == DF_LW) begin
              // Full aligned word: no need to read the old contents.
              mem_wdata <= wdata;
              mem_wr    <= 1'b1;
              state     <= ST_WR;
            end else begin
              mem_rd <= 1'b1;
              state  <= ST_RMW_RD;
            end
          end
        end
        ST_RD: begin
          if (mem_ack) begin
            rdata  <= load_data;
            mem_rd <= 1'b0;
            done   <= 1'b1;
            state  <= ST_DONE;
          end
        end
        ST_RMW_RD: begin
          if (mem_ack) begin
            mem_wdata <= store_word;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b1;
            state     <= ST_WR;
          end
        end
        ST_WR: begin
          if (mem_ack) begin
            mem_wr <= 1'b0;
            done   <= 1'b1;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          err   <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          mem_rd <= 1'b0;
          mem_wr <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_port.sv
module tb_data_mem_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, rw;
  logic [2:0]  dfunc;
  logic [31:0] addr, wdata, rt_old;
  logic [31:0] rdata;
  logic        done, err, busy;
  logic [29:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int vectors = 0;
  int miscompares = 0;

  bit [31:0]   mem [int unsigned];
  int          wait_cfg = 0;
  int          wcnt = 0;
  int          rd_cycles = 0;
  int          wr_cycles = 0;
  int          both_high = 0;
  logic [29:0] wr_addr_log [$];
  logic [31:0] wr_data_log [$];
  logic [29:0] rd_addr_last;

  always #5 clk = ~clk;

  data_mem_port dut (
    .clk       (clk),
    ._reset    (rst_n),
    .req       (req),
    .rw        (rw),
    .dfunc     (dfunc),
    .addr      (addr),
    .wdata     (wdata),
    .rt_old    (rt_old),
    .rdata     (rdata),
    .done      (done),
    .err       (err),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  function automatic bit [31:0] mem_get(input int unsigned a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  // SRAM model: acks after wait_cfg extra strobe cycles; data garbage unless acked.
  always @(negedge clk) begin
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    if (mem_rd && mem_wr) both_high++;
    if (mem_rd || mem_wr) begin
      if (mem_rd) rd_cycles++;
      else        wr_cycles++;
      if (wcnt >= wait_cfg) begin
        mem_ack = 1'b1;
        wcnt    = 0;
        if (mem_rd) begin
          mem_rdata    = mem_get(32'(mem_addr));
          rd_addr_last = mem_addr;
        end else begin
          mem[32'(mem_addr)] = mem_wdata;
          wr_addr_log.push_back(mem_addr);
          wr_data_log.push_back(mem_wdata);
        end
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_err(input logic [2:0] f, input logic [1:0] b);
    return (f == 3'd7) || ((f == 3'd1 || f == 3'd5) && b[0]) || (f == 3'd3 && b != 2'd0);
  endfunction

  // Byte-array reference: index 0 is the most significant byte.
  function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [1:0] b,
                                           input logic [31:0] w, input logic [31:0] rt);
    logic [7:0] mb [4];
    logic [7:0] rb [4];
    logic [7:0] ob [4];
    int bi;
    bi = int'(b);
    for (int i = 0; i < 4; i++) begin
      mb[i] = w[31-8*i -: 8];
      rb[i] = rt[31-8*i -: 8];
      ob[i] = 8'h0;
    end
    case (f)
      3'd0: return {{24{mb[bi][7]}}, mb[bi]};
      3'd4: return {24'h0, mb[bi]};
      3'd1: return {{16{mb[bi][7]}}, mb[bi], mb[bi+1]};
      3'd5: return {16'h0, mb[bi], mb[bi+1]};
      3'd3: return w;
      3'd2: begin
        for (int i = 0; i < 4; i++) ob[i] = (i + bi <= 3) ? mb[i+bi] : rb[i];
        return {ob[0], ob[1], ob[2], ob[3]};
      end
      3'd6: begin
        for (int i = 0; i < 4; i++) ob[i] = (i >= 3 - bi) ? mb[i-(3-bi)] : rb[i];
        return {ob[0], ob[1], ob[2], ob[3]};
      end
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] ref_store(input logic [2:0] f, input logic [1:0] b,
                                            input logic [31:0] old, input logic [31:0] wd);
    logic [7:0] ob [4];
    logic [7:0] wb [4];
    int bi;
    bi = int'(b);
    for (int i = 0; i < 4; i++) begin
      ob[i] = old[31-8*i -: 8];
      wb[i] = wd[31-8*i -: 8];
    end
    case (f)
      3'd0, 3'd4: ob[bi] = wb[3];
      3'd1, 3'd5: begin ob[bi] = wb[2]; ob[bi+1] = wb[3]; end
      3'd2: for (int j = 0; j < 4; j++) if (j >= bi) ob[j] = wb[j-bi];
      3'd6: for (int j = 0; j < 4; j++) if (j <= bi) ob[j] = wb[j+3-bi];
      default: return wd;
    endcase
    return {ob[0], ob[1], ob[2], ob[3]};
  endfunction

  task automatic scramble();
    req    = 1'($urandom);
    rw     = 1'($urandom);
    dfunc  = 3'($urandom);
    addr   = $urandom;
    wdata  = $urandom;
    rt_old = $urandom;
  endtask

  // Called at posedge+1 with the DUT in IDLE.
  task automatic run_access(input bit r, input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rt, input int wt,
                            output logic [31:0] got);
    bit          e_err, rmw;
    logic [31:0] old, e_rdata, e_wr;
    int          e_cyc, e_rd, e_wr_c, cyc;
    bit          busy_ok;
    e_err   = ref_err(f, a[1:0]);
    old     = mem_get(a[31:2]);
    rmw     = r && (f != 3'd3);
    e_rdata = (e_err || r) ? 32'h0 : ref_load(f, a[1:0], old, rt);
    e_wr    = rmw ? ref_store(f, a[1:0], old, wd) : wd;
    if (e_err)    e_cyc = 1;
    else if (rmw) e_cyc = 3 + 2 * wt;
    else          e_cyc = 2 + wt;
    e_rd   = (e_err || (r && !rmw)) ? 0 : wt + 1;
    e_wr_c = (!e_err && r) ? wt + 1 : 0;

    wait_cfg  = wt;
    rd_cycles = 0;
    wr_cycles = 0;
    wr_addr_log.delete();
    wr_data_log.delete();
    req = 1'b1; rw = r; dfunc = f; addr = a; wdata = wd; rt_old = rt;
    @(posedge clk); #1;
    scramble();
    cyc = 1;
    busy_ok = 1'b1;
    while (!done && cyc < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      scramble();
      cyc++;
    end
    req = 1'b0;
    got = rdata;
    chk("done_cycle", cyc, e_cyc);
    chk("done", 32'(done), 32'd1);
    chk("busy_during", 32'(busy_ok), 32'd1);
    chk("busy_in_done", 32'(busy), 32'd0);
    chk("err", 32'(err), 32'(e_err));
    if (!r || e_err) chk("rdata", rdata, e_rdata);
    chk("rd_strobe_cycles", rd_cycles, e_rd);
    chk("wr_strobe_cycles", wr_cycles, e_wr_c);
    if (e_rd > 0) chk("rd_addr", 32'(rd_addr_last), 32'(a[31:2]));
    if (e_wr_c > 0) begin
      chk("wr_count", wr_data_log.size(), 1);
      if (wr_data_log.size() > 0) begin
        chk("wr_addr", 32'(wr_addr_log[0]), 32'(a[31:2]));
        chk("wr_data", wr_data_log[0], e_wr);
      end
    end
    @(posedge clk); #1;
    chk("done_pulse_end", 32'(done), 32'd0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_rdata"}, rdata, 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_err"}, 32'(err), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
    chk({tag, "_mem_rd"}, 32'(mem_rd), 32'h0);
    chk({tag, "_mem_wr"}, 32'(mem_wr), 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
  endtask

  initial begin
    logic [31:0] got;
    logic [2:0]  f;
    logic [2:0]  st_funcs [6];
    bit          r;
    st_funcs = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
    rst_n = 1'b0;
    req = 1'b0; rw = 1'b0; dfunc = 3'd0; addr = 32'h0; wdata = 32'h0; rt_old = 32'h0;
    #1;
    chk_outputs_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    mem[32'h1003 >> 2] = 32'h1122_3380;
    run_access(1'b0, 3'd0, 32'h1003, 32'h0, 32'h0, 0, got);
    chk("lb_value", got, 32'hFFFF_FF80);
    run_access(1'b0, 3'd4, 32'h1003, 32'h0, 32'h0, 0, got);
    chk("lbu_value", got, 32'h0000_0080);

    mem[32'h2002 >> 2] = 32'h1122_3344;
    run_access(1'b1, 3'd1, 32'h2002, 32'h0000_BEEF, 32'h0, 0, got);
    chk("sh_mem", mem[32'h2002 >> 2], 32'h1122_BEEF);

    mem[32'h3001 >> 2] = 32'hAABB_CCDD;
    run_access(1'b0, 3'd2, 32'h3001, 32'h0, 32'h1122_3344, 0, got);
    chk("lwl_value", got, 32'hBBCC_DD44);
    run_access(1'b0, 3'd6, 32'h3001, 32'h0, 32'h1122_3344, 1, got);
    chk("lwr_value", got, 32'h1122_AABB);

    mem[32'h4000 >> 2] = 32'hAABB_CCDD;
    run_access(1'b1, 3'd6, 32'h4000, 32'h5566_7788, 32'h0, 0, got);
    chk("swr_mem", mem[32'h4000 >> 2], 32'h88BB_CCDD);

    run_access(1'b0, 3'd3, 32'h5002, 32'h0, 32'h0, 0, got);
    run_access(1'b0, 3'd7, 32'h5000, 32'h0, 32'h0, 0, got);
    run_access(1'b1, 3'd3, 32'h6000, 32'hCAFE_F00D, 32'h0, 3, got);
    chk("sw_mem", mem[32'h6000 >> 2], 32'hCAFE_F00D);

    // Reset while the write is pending.
    wait_cfg = 10;
    req = 1'b1; rw = 1'b1; dfunc = 3'd3; addr = 32'h7000; wdata = 32'h1234_5678;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    chk("pre_reset_mem_wr", 32'(mem_wr), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_idle_busy", 32'(busy), 32'd0);
    run_access(1'b0, 3'd3, 32'h1000, 32'h0, 32'h0, 0, got);

    for (int n = 0; n < 150; n++) begin
      r = 1'($urandom);
      f = r ? st_funcs[$urandom_range(0, 5)] : 3'($urandom);
      run_access(r, f, 32'h100 + 32'($urandom_range(0, 63)), $urandom, $urandom,
                 $urandom_range(0, 2), got);
    end

    chk("strobes_never_both", both_high, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_mem_port.md
# data_mem_port

Data-side memory responder for the MIPS core. It accepts the load/store command the controller issues (`rw`, `dfunc`, effective address, store data) and runs it against a word-wide, handshaked data SRAM that has no byte enables. Sub-word, unaligned-left/right and sign-extending accesses are built from whole-word reads and read-modify-write cycles. Loaded data returns to the register-file write path, and `busy` stalls fetch until the access completes.

## Interface
Parameters
- none; address and data widths are fixed at 32 bits, word address `[31:2]`

Ports
- `clk`  in  1  Core clock, rising edge.
- `_reset`  in  1  Asynchronous reset, active-low.
- `req`  in  1  Start an access; sampled only in IDLE.
- `rw`  in  1  1 = store, 0 = load.
- `dfunc`  in  3  Access type, equal to `opcode[2:0]`:
  - 000 b; 001 h; 010 wl; 011 w; 100 bu; 101 hu; 110 wr.
  - 111 is illegal.
- `addr`  in  32  Effective byte address.
- `wdata`  in  32  Store data (rt).
- `rt_old`  in  32  Current rt value, used for merging on lwl/lwr.
- `rdata`  out  32  Load result; valid while `done` = 1.
- `done`  out  1  One-cycle completion pulse.
- `err`  out  1  Alignment or illegal-function error; qualified by `done`.
- `busy`  out  1  High from the cycle after `req` is accepted until `done`.
- `mem_addr`  out  30  SRAM word address.
- `mem_rd`, `mem_wr`  out  1 each  SRAM read/write strobes; never both high.
- `mem_wdata`  out  32  SRAM write data.
- `mem_rdata`  in  32  SRAM read data; valid when `mem_ack` = 1.
- `mem_ack`  in  1  SRAM completion, sampled at the rising edge.

## Operation
- Byte order is big-endian. Let `b = addr[1:0]`; lane `b` = 0 is bits `[31:24]`.
- Alignment rules:
  - h/hu with `addr[0]` = 1 is an error.
  - w with `b` ≠ 0 is an error.
  - dfunc 111 is an error.
  - An error access issues no SRAM cycle. It goes directly to DONE with `err` = 1 and `rdata` = 0.
- Loads:
  - b/bu: sign- or zero-extend the selected byte.
  - h/hu: sign- or zero-extend the selected halfword.
  - w: the full word.
  - wl: `(mem << 8b) | (rt_old & ((1<<8b)-1))`.
  - wr: `(mem >> 8(3-b)) | (rt_old & ~(32'hFFFFFFFF >> 8(3-b)))`.
- Stores:
  - sw is a single write.
  - sb, sh, swl and swr always do a read-modify-write. Replaced lanes:
    - sb: lane `b` gets `wdata[7:0]`.
    - sh: lanes `b`, `b+1` get `wdata[15:0]`.
    - swl: `(old & ~(32'hFFFFFFFF >> 8b)) | (wdata >> 8b)`.
    - swr: `(old & ~(32'hFFFFFFFF << 8(3-b))) | (wdata << 8(3-b))`.
- FSM states: IDLE, RD, RMW_RD, WR, DONE.
  - IDLE, `req` = 1:
    - error → DONE;
    - load → RD;
    - sw → WR;
    - other store → RMW_RD.
  - RD / RMW_RD: hold `mem_rd` = 1.
    - On `mem_ack`, RD captures the load result into `rdata` → DONE.
    - On `mem_ack`, RMW_RD captures the merged word into the write buffer → WR.
  - WR: hold `mem_wr` = 1 with the buffered data. On `mem_ack` → DONE.
  - DONE: `done` = 1 for one cycle → IDLE. `req` is not accepted in DONE.
- `mem_addr`, `dfunc`, `b`, `wdata` and `rt_old` are latched at acceptance. Later changes to the inputs have no effect.
- Reset values: state IDLE; every output 0; internal registers 0.
- Reset asserted mid-access aborts immediately and drops the strobes. A pending SRAM write may or may not have committed.

## Timing
- Acceptance edge = E0; `busy` rises after E0.
- Load with ack at the first strobe edge:
  - strobe high in cycle 1;
  - `done` and `rdata` in cycle 2.
  - Each extra wait cycle adds one.
- sw: same timing as a load.
- RMW store with zero-wait SRAM:
  - read in cycle 1;
  - write in cycle 2;
  - `done` in cycle 3.
- Error access: `done` in cycle 1.
- `busy` = 1 in every non-IDLE state except DONE; in DONE, `busy` = 0 and `done` = 1.
- Strobes are registered outputs. They are glitch-free and stay stable until `mem_ack`.

## Structure
- Shared package / include: dfunc encodings (LB…LWR), the FSM state encoding, and a `BIG_ENDIAN` lane-index function.
- Sub-module `mem_align` (purely combinational) computes the load extract/merge and the store merge from `(dfunc, b, word, wdata, rt_old)`.
- `data_mem_port` keeps the FSM, the latches and the handshake.

## Test plan
- lb, addr 0x1003, word 0x11223380 → `rdata` 0xFFFFFF80. lbu on the same word → 0x00000080. `done` in cycle 2 with zero wait.
- sh `wdata` 0x0000BEEF at addr 0x2002, old word 0x11223344:
  - one read, then a write of 0x1122BEEF;
  - `done` in cycle 3.
- lwl addr 0x3001, mem 0xAABBCCDD, `rt_old` 0x11223344 → 0xBBCCDD44. lwr with `b` = 1 → 0x1122AABB.
- swr `wdata` 0x55667788 at addr 0x4000, old 0xAABBCCDD → SRAM written with 0x88BBCCDD.
- lw addr 0x5002 → `err` = 1, `done` in cycle 1, `mem_rd` never asserted. dfunc 111 behaves the same.
- sw with 3 wait cycles → `mem_wr` held for 4 cycles. Additional checks:
  - `req` toggled during the access is ignored.
  - `_reset` asserted in the WR state → all outputs 0 immediately, FSM in IDLE.
